// File: rtl/serial_deser_rx.sv
// Serial frame receiver: start bit, WIDTH data bits (either bit order), optional parity, stop bit.
// One bit is taken per clk edge with en=1; the word is presented with a one-cycle dvalid pulse.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (sdi=0)
// DATA   | shifting in WIDTH data bits
// PAR    | sampling the parity bit
// STOP   | sampling the stop bit, delivering the word or flagging a framing error
// HUNT   | after a framing error, waiting for the line to return high
module serial_deser_rx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int ODD       = 0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             sdi,
  input  logic             msb_first,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             perr,
  output logic             ferr,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP,
    S_HUNT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_par;
  logic             r_mode;
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic             r_perr;
  logic             r_ferr;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_par_nxt;
  logic             w_mode_nxt;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_dvalid_nxt;
  logic             w_perr_nxt;
  logic             w_ferr_nxt;
  logic             w_last_bit;

  assign w_last_bit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_par    <= 1'b0;
      r_mode   <= 1'b0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_cnt    <= w_cnt_nxt;
      r_par    <= w_par_nxt;
      r_mode   <= w_mode_nxt;
      r_dout   <= w_dout_nxt;
      r_dvalid <= w_dvalid_nxt;
      r_perr   <= w_perr_nxt;
      r_ferr   <= w_ferr_nxt;
    end
  end

  // Pulses default low every cycle so they last one clk regardless of en.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_cnt_nxt    = r_cnt;
    w_par_nxt    = r_par;
    w_mode_nxt   = r_mode;
    w_dout_nxt   = r_dout;
    w_dvalid_nxt = 1'b0;
    w_perr_nxt   = 1'b0;
    w_ferr_nxt   = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE: begin
          if (!sdi) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
            w_par_nxt   = (ODD != 0);
            w_mode_nxt  = msb_first;
          end
        end
        S_DATA: begin
          if (r_mode) begin
            w_shreg_nxt = {r_shreg[WIDTH-2:0], sdi};
          end else begin
            w_shreg_nxt = {sdi, r_shreg[WIDTH-1:1]};
          end
          w_par_nxt = r_par ^ sdi;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last_bit) begin
            w_state_nxt = (PARITY_EN != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          w_par_nxt   = r_par ^ sdi;
          w_state_nxt = S_STOP;
        end
        S_STOP: begin
          if (sdi) begin
            w_dout_nxt   = r_shreg;
            w_dvalid_nxt = 1'b1;
            w_perr_nxt   = (PARITY_EN != 0) && r_par;
            w_state_nxt  = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_HUNT;
          end
        end
        S_HUNT: begin
          if (sdi) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign dout   = r_dout;
  assign dvalid = r_dvalid;
  assign perr   = r_perr;
  assign ferr   = r_ferr;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_deser_rx.sv
// Bench for serial_deser_rx: directed frames plus random frames against a word-level model.
module tb_serial_deser_rx;

  localparam int W   = 8;
  localparam int ODD = 0;

  logic         clk = 1'b0;
  logic         clrn;
  logic         en;
  logic         sdi;
  logic         msb_first;
  logic [W-1:0] dout;
  logic         dvalid;
  logic         perr;
  logic         ferr;
  logic         busy;

  int           n_chk  = 0;
  int           n_pass = 0;
  logic [W-1:0] model_dout;

  serial_deser_rx #(.WIDTH(W), .PARITY_EN(1), .ODD(ODD)) u_dut (
    .clk       (clk),
    .clrn      (clrn),
    .en        (en),
    .sdi       (sdi),
    .msb_first (msb_first),
    .dout      (dout),
    .dvalid    (dvalid),
    .perr      (perr),
    .ferr      (ferr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bit per en tick; en is high only on the last of 'period' cycles.
  task automatic send_bit(input logic b, input int period, input logic exp_busy);
    for (int k = 0; k < period; k++) begin
      en  = (k == period - 1);
      sdi = b;
      @(posedge clk);
      #1;
      if (k != period - 1) begin
        chk("hold_busy", 32'(busy), 32'(exp_busy));
        chk("hold_dvalid", 32'(dvalid), 32'd0);
        chk("hold_dout", 32'(dout), 32'(model_dout));
      end
    end
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic msb, input logic par_bad,
                            input logic stop_b, input int period, input logic toggle);
    logic pbit;
    logic exp_perr;
    logic b;
    int   ones;
    ones     = $countones(word);
    pbit     = ((ones % 2) != ODD) ^ par_bad;
    exp_perr = (((ones + int'(pbit)) % 2) != ODD);
    msb_first = msb;
    send_bit(1'b0, period, 1'b0);
    chk("busy_start", 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      b = msb ? word[W-1-i] : word[i];
      send_bit(b, period, 1'b1);
      if (toggle && i == 2) msb_first = ~msb;
    end
    send_bit(pbit, period, 1'b1);
    send_bit(stop_b, period, 1'b1);
    if (stop_b) begin
      model_dout = word;
      chk("dvalid", 32'(dvalid), 32'd1);
      chk("dout", 32'(dout), 32'(word));
      chk("perr", 32'(perr), 32'(exp_perr));
      chk("ferr_clean", 32'(ferr), 32'd0);
      chk("busy_done", 32'(busy), 32'd0);
    end else begin
      chk("ferr", 32'(ferr), 32'd1);
      chk("dvalid_ferr", 32'(dvalid), 32'd0);
      chk("dout_ferr", 32'(dout), 32'(model_dout));
      chk("busy_hunt", 32'(busy), 32'd1);
    end
  endtask

  // Pulse-width check: one more edge with en=0 must clear every pulse.
  task automatic idle_cycle(input logic exp_busy);
    en  = 1'b0;
    sdi = 1'b1;
    @(posedge clk);
    #1;
    chk("pulse_dvalid", 32'(dvalid), 32'd0);
    chk("pulse_ferr", 32'(ferr), 32'd0);
    chk("pulse_busy", 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    logic [W-1:0] rw;
    logic         rmsb;
    logic         rpar;
    logic         rstop;
    int           rper;
    int           rgap;
    int           rbrk;

    clrn       = 1'b0;
    en         = 1'b0;
    sdi        = 1'b1;
    msb_first  = 1'b1;
    model_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dvalid", 32'(dvalid), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    chk("rst_ferr", 32'(ferr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    send_frame(8'hB2, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    idle_cycle(1'b0);
    send_frame(8'h4D, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    idle_cycle(1'b0);
    send_frame(8'hB2, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    idle_cycle(1'b0);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0, 1, 1'b1);
      chk("brk_busy", 32'(busy), 32'd1);
      chk("brk_dvalid", 32'(dvalid), 32'd0);
      chk("brk_ferr", 32'(ferr), 32'd0);
      chk("brk_dout", 32'(dout), 32'hB2);
    end
    send_bit(1'b1, 1, 1'b1);
    chk("brk_release", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1, 1'b0);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 4, 1'b1);
    idle_cycle(1'b0);

    msb_first = 1'b1;
    send_bit(1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1, 1'b1);
    #2;
    clrn = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_dvalid", 32'(dvalid), 32'd0);
    chk("arst_perr", 32'(perr), 32'd0);
    chk("arst_ferr", 32'(ferr), 32'd0);
    model_dout = '0;
    sdi = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    idle_cycle(1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1, 1'b0);

    // Random frames, back-to-back or with idle gaps, including parity and framing faults.
    for (int n = 0; n < 60; n++) begin
      rw    = W'($urandom);
      rmsb  = 1'($urandom);
      rpar  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 7) != 0);
      rper  = $urandom_range(1, 3);
      rgap  = $urandom_range(0, 2);
      send_frame(rw, rmsb, rpar, rstop, rper, 1'($urandom));
      if (!rstop) begin
        rbrk = $urandom_range(0, 3);
        for (int k = 0; k < rbrk; k++) send_bit(1'b0, rper, 1'b1);
        send_bit(1'b1, rper, 1'b1);
        chk("rnd_hunt_exit", 32'(busy), 32'd0);
      end
      for (int k = 0; k < rgap; k++) send_bit(1'b1, rper, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_deser_rx.md
Name: serial_deser_rx

Overview:
- Serial-to-parallel frame receiver. It is the receiving end of the serial stream that the team's 8-bit universal shift register produces when used as a transmitter.
- Each frame is: start bit (0), WIDTH data bits (MSB-first or LSB-first), optional parity bit, stop bit (1).
- One bit is sampled per clk cycle in which the bit-tick enable is high. The received word is presented in parallel with a one-cycle valid pulse and error flags.

Parameters:
- WIDTH, 8, number of data bits per frame (valid range 2..16).
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- ODD, 0, 0 = even parity (data bits plus parity bit contain an even number of 1s); 1 = odd parity.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clrn  input  1  asynchronous, active-low reset.
- en  input  1  bit tick; sdi is sampled only on rising edges where en=1.
- sdi  input  1  serial data in; idle level is 1.
- msb_first  input  1  1 = first data bit is the MSB (matches a left-shifting transmitter); 0 = first data bit is the LSB (matches a right-shifting transmitter).
- dout  output  WIDTH  last correctly framed word; held between frames.
- dvalid  output  1  one-cycle pulse when dout updates.
- perr  output  1  parity error flag; valid only while dvalid=1.
- ferr  output  1  one-cycle pulse when the stop bit is 0.
- busy  output  1  1 while the state is not IDLE.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE; shift register, bit counter and parity accumulator cleared.
  - dout=0, dvalid=0, perr=0, ferr=0, busy=0.
  - Reset mid-frame discards the partial frame. The first frame after release needs a fresh start bit.
- When en=0, nothing changes except that the dvalid/perr/ferr pulses clear. Pulses last exactly one clk cycle, independent of en.
- States: IDLE, DATA, PAR, STOP, HUNT. All transitions happen only on edges where en=1.
- IDLE:
  - sdi=0 → go to DATA; cnt=0; parity accumulator=ODD; latch msb_first into mode_r.
  - Otherwise stay in IDLE.
- DATA:
  - mode_r=1: shreg <= {shreg[WIDTH-2:0], sdi} (shift left, insert at bit 0).
  - mode_r=0: shreg <= {sdi, shreg[WIDTH-1:1]} (shift right, insert at bit WIDTH-1).
  - Parity accumulator ^= sdi; cnt increments.
  - When cnt = WIDTH-1 on a sample edge, go to PAR if PARITY_EN=1, else STOP.
- PAR: parity accumulator ^= sdi; go to STOP.
- STOP:
  - sdi=1: dout <= shreg; dvalid=1 next cycle. perr = final accumulator (1 = mismatch); forced 0 when PARITY_EN=0. The word is delivered even when perr=1. Go to IDLE.
  - sdi=0: ferr=1 next cycle; dout unchanged; dvalid stays 0; go to HUNT.
- HUNT: wait for sdi=1 on an en edge, then go to IDLE. A low line (break) is never taken as a start bit.
- Latency: dvalid is asserted the cycle after the stop-bit sample edge.
- msb_first changes mid-frame have no effect; mode_r is used until the next start bit.
- Back-to-back frames: a start bit on the en edge immediately after STOP is accepted. No idle bit is required.
- busy rises on the edge that accepts the start bit and falls on the edge that leaves STOP or HUNT.

Test Plan:
- WIDTH=8, PARITY_EN=1, ODD=0, msb_first=1, en=1 every cycle. Send start, bits 1,0,1,1,0,0,1,0, parity 0, stop 1 → dout=8'hB2, dvalid high one cycle, perr=0, ferr=0, busy low afterwards.
- Same bit stream with msb_first=0 → dout=8'h4D, perr=0.
- Send 8'hB2 MSB-first with parity bit 1 → dout=8'hB2, dvalid=1, perr=1.
- Send a frame with stop bit 0, then hold sdi=0 for 5 ticks, then sdi=1, then a clean 8'h3C frame:
  - ferr pulses once, dout stays 8'hB2, no dvalid during the low period.
  - The next frame gives dout=8'h3C, dvalid=1.
- en high only every 4th cycle, frame 8'hA5; toggle msb_first after the 3rd data bit:
  - Result matches the mode latched at the start bit (8'hA5).
  - State is unchanged on en=0 cycles.
  - dvalid width is 1 clk.
- Pull clrn low after the 4th data bit, release, then send 8'h81 → all outputs 0 during reset, then dout=8'h81 with no residue from the aborted frame.
